// File: rtl/mpsoc_gpio_irq.sv
// APB3-Lite GPIO interrupt controller: pad synchroniser, per-bit edge detect, W1C pending, level irq.
// Optional per-bit debounce filter enabled by defining MPSOC_GPIO_IRQ_DEBOUNCE_EN.
module mpsoc_gpio_irq #(
    parameter int unsigned PADDR_SIZE      = 64,
    parameter int unsigned PDATA_SIZE      = 64,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                    PRESETn,
    input  logic                    PCLK,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [PDATA_SIZE-1:0]   gpio_i,
    output logic                    irq_o
);

    localparam int unsigned NumLanes = PDATA_SIZE / 8;

    logic [PDATA_SIZE-1:0] ien_q, ien_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [PDATA_SIZE-1:0] pending_q, pending_d, prdata_q, rd_data;
    logic [PDATA_SIZE-1:0] sync1_q, sync2_q, prev_q, lvl;
    logic [PDATA_SIZE-1:0] wmask, clr, rise, fall;
    logic                  init_q, irq_q, wr_en, rd_en;
    logic [2:0]            idx;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & ~PENABLE & ~PWRITE;
    assign idx     = PADDR[2:0];
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign PRDATA  = prdata_q;
    assign irq_o   = irq_q;

    logic unused_addr;
    assign unused_addr = ^PADDR[PADDR_SIZE-1:3];

`ifdef MPSOC_GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [PDATA_SIZE-1:0] lvl_q;
    logic [CntW-1:0]       cnt_q [PDATA_SIZE];

    // A bit's counter runs only while the synchronised value disagrees with lvl.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lvl_q <= '0;
            for (int i = 0; i < PDATA_SIZE; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < PDATA_SIZE; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntLast) begin
                    lvl_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != {CntW{1'b1}}) begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign lvl = lvl_q;
`else
    logic [31:0] unused_debounce;
    assign unused_debounce = 32'(DEBOUNCE_CYCLES);
    assign lvl             = sync2_q;
`endif

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NumLanes; b++) wmask[b*8 +: 8] = {8{PSTRB[b]}};
    end

    always_comb begin
        ien_d     = ien_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en) begin
            case (idx)
                3'd0:    ien_d     = (ien_q & ~wmask) | (PWDATA & wmask);
                3'd1:    rise_en_d = (rise_en_q & ~wmask) | (PWDATA & wmask);
                3'd2:    fall_en_d = (fall_en_q & ~wmask) | (PWDATA & wmask);
                3'd3:    clr       = PWDATA & wmask;
                default: ;
            endcase
        end
        // init_q masks the first post-reset cycle while prev catches up with lvl.
        rise      = init_q ? '0 : (lvl & ~prev_q & rise_en_q);
        fall      = init_q ? '0 : (~lvl & prev_q & fall_en_q);
        pending_d = (pending_q & ~clr) | rise | fall;
    end

    always_comb begin
        case (idx)
            3'd0:    rd_data = ien_q;
            3'd1:    rd_data = rise_en_q;
            3'd2:    rd_data = fall_en_q;
            3'd3:    rd_data = pending_q;
            3'd4:    rd_data = lvl;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            init_q    <= 1'b1;
            ien_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            prdata_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= gpio_i;
            sync2_q   <= sync1_q;
            prev_q    <= lvl;
            init_q    <= 1'b0;
            ien_q     <= ien_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pending_q <= pending_d;
            irq_q     <= |(pending_q & ien_q);
            if (rd_en) prdata_q <= rd_data;
        end
    end

endmodule
